// File: rtl/tnoc_axi_write_id_tracker.sv
// Maps wide NoC write IDs onto a small pool of AXI awid slots and restores
// the NoC ID on each B response through a one-entry response register.
module tnoc_axi_write_id_tracker #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int NOC_ID_WIDTH    = 8,
    localparam int SLOT_WIDTH     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_aw_valid,
    output logic                    o_aw_ready,
    input  logic [NOC_ID_WIDTH-1:0] i_aw_noc_id,
    output logic                    o_axi_awvalid,
    input  logic                    i_axi_awready,
    output logic [SLOT_WIDTH-1:0]   o_axi_awid,
    input  logic                    i_axi_bvalid,
    output logic                    o_axi_bready,
    input  logic [SLOT_WIDTH-1:0]   i_axi_bid,
    input  logic [1:0]              i_axi_bresp,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [NOC_ID_WIDTH-1:0] o_rsp_noc_id,
    output logic [1:0]              o_rsp_status,
    output logic [SLOT_WIDTH:0]     o_outstanding,
    output logic                    o_full,
    output logic                    o_err_unknown_bid
);
    localparam logic [SLOT_WIDTH:0] MAX_CNT = (SLOT_WIDTH+1)'(MAX_OUTSTANDING);
    localparam logic [SLOT_WIDTH:0] ONE     = (SLOT_WIDTH+1)'(1);

    logic [MAX_OUTSTANDING-1:0] valid_q, valid_d;
    logic [NOC_ID_WIDTH-1:0]    noc_q [MAX_OUTSTANDING];
    logic [SLOT_WIDTH:0]        cnt_q, cnt_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic [NOC_ID_WIDTH-1:0]    rsp_id_q, rsp_id_d;
    logic [1:0]                 rsp_st_q, rsp_st_d;
    logic                       err_q;

    logic                       alloc, b_hs, free, known;
    logic [SLOT_WIDTH-1:0]      free_idx;
    logic [NOC_ID_WIDTH-1:0]    bid_noc_id;

    assign o_full        = (cnt_q == MAX_CNT);
    assign o_axi_awvalid = i_aw_valid & ~o_full & ~rst;
    assign o_aw_ready    = i_axi_awready & ~o_full & ~rst;
    assign o_axi_awid    = free_idx;
    assign alloc         = o_axi_awvalid & i_axi_awready;
    assign o_axi_bready  = ~rsp_valid_q | i_rsp_ready;
    assign b_hs          = i_axi_bvalid & o_axi_bready;
    assign free          = b_hs & known;

    // Scan high-to-low so the lowest free index wins.
    always_comb begin
        free_idx = '0;
        for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = SLOT_WIDTH'(i);
        end
    end

    // Out-of-range bids never match a slot, so they fall out as unknown.
    always_comb begin
        known      = 1'b0;
        bid_noc_id = '0;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (i_axi_bid == SLOT_WIDTH'(i) && valid_q[i]) begin
                known      = 1'b1;
                bid_noc_id = noc_q[i];
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (alloc && free_idx == SLOT_WIDTH'(i)) valid_d[i] = 1'b1;
            if (free && i_axi_bid == SLOT_WIDTH'(i)) valid_d[i] = 1'b0;
        end
        cnt_d = cnt_q;
        if (alloc && !free)      cnt_d = cnt_q + ONE;
        else if (!alloc && free) cnt_d = cnt_q - ONE;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_st_d    = rsp_st_q;
        if (free) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = bid_noc_id;
            rsp_st_d    = i_axi_bresp;
        end else if (i_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_st_q    <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) noc_q[i] <= '0;
        end else begin
            valid_q     <= valid_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_st_q    <= rsp_st_d;
            err_q       <= b_hs & ~known;
            if (alloc) noc_q[free_idx] <= i_aw_noc_id;
        end
    end

    assign o_rsp_valid       = rsp_valid_q;
    assign o_rsp_noc_id      = rsp_id_q;
    assign o_rsp_status      = rsp_st_q;
    assign o_outstanding     = cnt_q;
    assign o_err_unknown_bid = err_q;
endmodule

// File: tb/tb_tnoc_axi_write_id_tracker.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// slot-table/queue model of the tracker.
module tb_tnoc_axi_write_id_tracker;
    localparam int N = 4;

    logic       clk = 0, rst = 1;
    logic       aw_valid = 0, awready = 0, bvalid = 0, rsp_ready = 0;
    logic [7:0] aw_noc_id = 0;
    logic [1:0] bid = 0, bresp = 0;
    logic       aw_ready, awvalid, bready, rsp_valid, full, err;
    logic [1:0] awid, rsp_st;
    logic [7:0] rsp_id;
    logic [2:0] outstanding;

    tnoc_axi_write_id_tracker #(.MAX_OUTSTANDING(N), .NOC_ID_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .i_aw_valid(aw_valid), .o_aw_ready(aw_ready), .i_aw_noc_id(aw_noc_id),
        .o_axi_awvalid(awvalid), .i_axi_awready(awready), .o_axi_awid(awid),
        .i_axi_bvalid(bvalid), .o_axi_bready(bready), .i_axi_bid(bid), .i_axi_bresp(bresp),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_noc_id(rsp_id),
        .o_rsp_status(rsp_st), .o_outstanding(outstanding), .o_full(full),
        .o_err_unknown_bid(err)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;

    // Model: which slots hold a write, their IDs, and the pending response.
    bit       m_used [N];
    bit [7:0] m_id   [N];
    bit       m_rv;
    bit [7:0] m_rid;
    bit [1:0] m_rst;
    bit       m_err;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int used_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += m_used[i];
        return c;
    endfunction

    function automatic int lowest_free();
        for (int i = 0; i < N; i++) if (!m_used[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin m_used[i] = 0; m_id[i] = 0; end
        m_rv = 0; m_rid = 0; m_rst = 0; m_err = 0;
    endtask

    // Called at a negedge with inputs already driven: check, then advance one clock.
    task automatic cyc();
        int  cnt, lf;
        bit  e_awv, e_br, alloc, hs, known;
        if (rst) model_reset();
        #1;
        cnt   = used_count();
        lf    = lowest_free();
        e_awv = !rst && aw_valid && cnt != N;
        e_br  = !m_rv || rsp_ready;
        chk("awvalid", awvalid, e_awv);
        chk("aw_ready", aw_ready, !rst && awready && cnt != N);
        if (cnt != N) chk("awid", awid, lf);
        chk("bready", bready, e_br);
        chk("rsp_valid", rsp_valid, m_rv);
        chk("rsp_noc_id", rsp_id, m_rid);
        chk("rsp_status", rsp_st, m_rst);
        chk("outstanding", outstanding, cnt);
        chk("full", full, cnt == N);
        chk("err", err, m_err);
        alloc = e_awv && awready;
        hs    = bvalid && e_br;
        known = hs && m_used[bid];
        @(posedge clk);
        if (rst) model_reset();
        else begin
            if (known) begin
                m_rv = 1; m_rid = m_id[bid]; m_rst = bresp; m_used[bid] = 0;
            end else if (rsp_ready) m_rv = 0;
            m_err = hs && !known;
            if (alloc) begin m_used[lf] = 1; m_id[lf] = aw_noc_id; end
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        // Reset holds the AW path off even with a request pending.
        rst = 1; aw_valid = 1; awready = 1;
        #1 chk("rst_awvalid", awvalid, 0);
        chk("rst_outstanding", outstanding, 0);
        cyc(); cyc();
        rst = 0; rsp_ready = 1;
        // Fill all slots.
        for (int k = 0; k < N; k++) begin
            aw_noc_id = 8'(8'h11 * (k + 1));
            #1 chk("fill_awid", awid, k);
            cyc();
        end
        #1 chk("fill_full", full, 1);
        chk("fill_stall", awvalid, 0);
        chk("fill_cnt", outstanding, 4);
        cyc();
        aw_valid = 0;
        // Out-of-order B.
        bvalid = 1; bid = 2; bresp = 2;
        cyc();
        bid = 0; bresp = 0;
        #1 chk("ooo1_id", rsp_id, 8'h33);
        chk("ooo1_st", rsp_st, 2);
        cyc();
        bvalid = 0;
        #1 chk("ooo2_id", rsp_id, 8'h11);
        chk("ooo2_st", rsp_st, 0);
        aw_valid = 1; aw_noc_id = 8'h55;
        #1 chk("ooo_awid", awid, 0);
        cyc();
        aw_valid = 0;
        // Backpressure: second B waits for the packer.
        rsp_ready = 0; bvalid = 1; bid = 1; bresp = 1;
        cyc();
        bid = 3;
        #1 chk("bp_bready", bready, 0);
        cyc(); cyc();
        chk("bp_hold", rsp_id, 8'h22);
        rsp_ready = 1;
        #1 chk("bp_bready2", bready, 1);
        cyc();
        bvalid = 0;
        #1 chk("bp_second", rsp_id, 8'h44);
        cyc();
        // Full, then free slot 1 while a request waits.
        aw_valid = 1;
        for (int k = 0; k < 3; k++) begin aw_noc_id = 8'(8'hA0 + k); cyc(); end
        #1 chk("f5_full", full, 1);
        bvalid = 1; bid = 1; bresp = 0;
        cyc();
        bvalid = 0;
        #1 chk("f5_drop", full, 0);
        chk("f5_awid", awid, 1);
        cyc();
        #1 chk("f5_refull", full, 1);
        aw_valid = 0;
        bvalid = 1;
        for (int k = 0; k < N; k++) begin bid = 2'(k); cyc(); end
        bvalid = 0; cyc();
        // Unknown bid on an empty table.
        bvalid = 1; bid = 3;
        #1 chk("unk_bready", bready, 1);
        cyc();
        bvalid = 0;
        #1 chk("unk_err", err, 1);
        chk("unk_rsp", rsp_valid, 0);
        chk("unk_cnt", outstanding, 0);
        cyc();
        #1 chk("unk_err_clr", err, 0);
        // Randomized traffic with occasional mid-operation resets.
        for (int c = 0; c < 3000; c++) begin
            int pick;
            rst       = ($urandom_range(0, 249) == 0);
            aw_valid  = $urandom_range(0, 2) != 0;
            awready   = $urandom_range(0, 3) != 0;
            aw_noc_id = 8'($urandom);
            bvalid    = $urandom_range(0, 1);
            rsp_ready = $urandom_range(0, 3) != 0;
            bresp     = 2'($urandom);
            bid       = 2'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                pick = $urandom_range(0, N - 1);
                for (int k = 0; k < N; k++)
                    if (m_used[(pick + k) % N]) begin bid = 2'((pick + k) % N); break; end
            end
            cyc();
        end
        rst = 1; aw_valid = 0; bvalid = 0;
        #1 chk("midrst_cnt", outstanding, 0);
        chk("midrst_rsp", rsp_valid, 0);
        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
